// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// Holds the TX sequencer state encoding and the TSR handshake widths.
package uart_pkg;

    typedef enum logic [2:0] {
        TXC_IDLE,
        TXC_POP,
        TXC_START,
        TXC_SEND,
        TXC_GAP
    } tx_ctrl_state_e;

    localparam int unsigned TSR_DATA_W = 8;
    localparam int unsigned GAP_CNT_W  = 8;

endpackage

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: pops the TX buffer into the TSR under enable/break/CTS gating,
// inserts an optional inter-frame gap, and produces THRE/TEMT status and the THRE interrupt pulse.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  utrst,
    input  logic                  brk,
    input  logic                  afe,
    input  logic                  cts_n,
    input  logic                  tx_fifo_empty,
    input  logic [TSR_DATA_W-1:0] tx_data,
    input  logic                  tsr_busy,
    input  logic                  tsr_done,
    output logic                  tsr_load,
    output logic                  tsr_start,
    output logic [TSR_DATA_W-1:0] tsr_data,
    output logic                  thre,
    output logic                  temt,
    output logic                  thre_pulse,
    output logic [CNT_W-1:0]      tx_count
);

    localparam bit                   HasGap  = (GAP_CYCLES > 0);
    localparam logic [GAP_CNT_W-1:0] GapLoad = HasGap ? GAP_CNT_W'(GAP_CYCLES - 1) : '0;

    tx_ctrl_state_e        state_q, state_d;
    logic [GAP_CNT_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [TSR_DATA_W-1:0] tsr_data_q;
    logic [CNT_W-1:0]      count_q;
    logic                  thre_q;
    logic                  thre_pulse_q;
    logic                  go;
    logic                  frame_done;

    // Gating is only consulted here, so a frame already popped always runs to completion.
    assign go = utrst & ~brk & ~tx_fifo_empty & ~tsr_busy & ~(afe & cts_n);

    assign frame_done = (state_q == TXC_SEND) & tsr_done;

    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        unique case (state_q)
            TXC_IDLE: begin
                if (go) begin
                    state_d = TXC_POP;
                end
            end
            TXC_POP: begin
                state_d = TXC_START;
            end
            TXC_START: begin
                state_d = TXC_SEND;
            end
            TXC_SEND: begin
                if (tsr_done) begin
                    if (HasGap) begin
                        state_d   = TXC_GAP;
                        gap_cnt_d = GapLoad;
                    end else begin
                        state_d = TXC_IDLE;
                    end
                end
            end
            TXC_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = TXC_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d   = TXC_IDLE;
                gap_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q   <= TXC_IDLE;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    // Buffer head is fall-through, so it is valid during the pop cycle itself.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            tsr_data_q <= '0;
        end else if (state_q == TXC_POP) begin
            tsr_data_q <= tx_data;
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            count_q <= '0;
        end else if (frame_done) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    // thre_q starts high so that an empty buffer out of reset raises no interrupt.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            thre_q       <= 1'b1;
            thre_pulse_q <= 1'b0;
        end else begin
            thre_q       <= tx_fifo_empty;
            thre_pulse_q <= tx_fifo_empty & ~thre_q;
        end
    end

    // Strobes decode straight from state so reset drops them without waiting for a clock.
    assign tsr_load   = (state_q == TXC_POP);
    assign tsr_start  = (state_q == TXC_START);
    assign tsr_data   = tsr_data_q;
    assign thre       = tx_fifo_empty;
    assign temt       = tx_fifo_empty & (state_q == TXC_IDLE) & ~tsr_busy;
    assign thre_pulse = thre_pulse_q;
    assign tx_count   = count_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: a no-gap 16-bit-count instance and a 4-cycle-gap
// instance with a 2-bit count so the counter wrap is reached in a few frames.
module tb_uart_tx_ctrl;

    logic pclk = 1'b0;
    always #5 pclk = ~pclk;

    logic preset, utrst, brk, afe, cts_n;

    logic        empty_a, busy_a, done_a;
    logic [7:0]  data_a;
    logic        load_a, start_a, thre_a, temt_a, pulse_a;
    logic [7:0]  tdata_a;
    logic [15:0] cnt_a;

    logic        empty_b, busy_b, done_b;
    logic [7:0]  data_b;
    logic        load_b, start_b, thre_b, temt_b, pulse_b;
    logic [7:0]  tdata_b;
    logic [1:0]  cnt_b;

    int total = 0;
    int bad   = 0;

    uart_tx_ctrl #(.GAP_CYCLES(0), .CNT_W(16)) dut_a (
        .pclk(pclk), .preset(preset), .utrst(utrst), .brk(brk), .afe(afe), .cts_n(cts_n),
        .tx_fifo_empty(empty_a), .tx_data(data_a), .tsr_busy(busy_a), .tsr_done(done_a),
        .tsr_load(load_a), .tsr_start(start_a), .tsr_data(tdata_a), .thre(thre_a),
        .temt(temt_a), .thre_pulse(pulse_a), .tx_count(cnt_a)
    );

    uart_tx_ctrl #(.GAP_CYCLES(4), .CNT_W(2)) dut_b (
        .pclk(pclk), .preset(preset), .utrst(utrst), .brk(brk), .afe(afe), .cts_n(cts_n),
        .tx_fifo_empty(empty_b), .tx_data(data_b), .tsr_busy(busy_b), .tsr_done(done_b),
        .tsr_load(load_b), .tsr_start(start_b), .tsr_data(tdata_b), .thre(thre_b),
        .temt(temt_b), .thre_pulse(pulse_b), .tx_count(cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge pclk);
    endtask

    // Entered in the START cycle of the previous frame with exp_byte already at the buffer head.
    task automatic frame_b(input logic [7:0] exp_byte, input logic [7:0] after,
                           input logic after_empty, input logic [1:0] exp_cnt);
        int load_k  = 0;
        int start_k = 0;
        step(); busy_b = 1'b1;
        step();
        step(); done_b = 1'b1; #1;
        for (int k = 1; k <= 20 && start_k == 0; k++) begin
            step(); done_b = 1'b0; busy_b = 1'b0; #1;
            if (k == 1) check("b_count", 32'(cnt_b), 32'(exp_cnt));
            if (load_b && load_k == 0) load_k = k;
            if (start_b) begin
                start_k = k;
                check("b_data", 32'(tdata_b), 32'(exp_byte));
                data_b  = after;
                empty_b = after_empty;
            end
        end
        check("b_load_lat", 32'(load_k), 32'd6);
        check("b_start_lat", 32'(start_k), 32'd7);
    endtask

    initial begin
        preset = 1'b1; utrst = 1'b1; brk = 1'b0; afe = 1'b0; cts_n = 1'b0;
        empty_a = 1'b1; data_a = 8'h00; busy_a = 1'b0; done_a = 1'b0;
        empty_b = 1'b1; data_b = 8'h00; busy_b = 1'b0; done_b = 1'b0;
        #1;
        check("rst_load", 32'(load_a), 32'd0);
        check("rst_start", 32'(start_a), 32'd0);
        check("rst_data", 32'(tdata_a), 32'h00);
        check("rst_pulse", 32'(pulse_a), 32'd0);
        check("rst_count", 32'(cnt_a), 32'd0);
        check("rst_thre", 32'(thre_a), 32'd1);
        check("rst_temt", 32'(temt_a), 32'd1);
        step(); preset = 1'b0;
        repeat (3) begin
            step(); #1;
            check("idle_load", 32'(load_a), 32'd0);
            check("idle_pulse", 32'(pulse_a), 32'd0);
            check("idle_temt", 32'(temt_a), 32'd1);
        end

        // Single byte, no gap
        step(); empty_a = 1'b0; data_a = 8'hA5; #1;
        check("a5_thre", 32'(thre_a), 32'd0);
        check("a5_temt", 32'(temt_a), 32'd0);
        check("a5_load_n", 32'(load_a), 32'd0);
        step(); #1;
        check("a5_load", 32'(load_a), 32'd1);
        check("a5_start_n", 32'(start_a), 32'd0);
        step(); empty_a = 1'b1; data_a = 8'h00; #1;
        check("a5_start", 32'(start_a), 32'd1);
        check("a5_load_off", 32'(load_a), 32'd0);
        check("a5_data", 32'(tdata_a), 32'hA5);
        step(); busy_a = 1'b1; #1;
        check("a5_pulse", 32'(pulse_a), 32'd1);
        check("a5_send_temt", 32'(temt_a), 32'd0);
        step(); #1;
        check("a5_pulse_once", 32'(pulse_a), 32'd0);
        step(); done_a = 1'b1; #1;
        check("a5_cnt_pre", 32'(cnt_a), 32'd0);
        step(); done_a = 1'b0; busy_a = 1'b0; #1;
        check("a5_cnt", 32'(cnt_a), 32'd1);
        check("a5_temt_end", 32'(temt_a), 32'd1);
        check("a5_no_pop", 32'(load_a), 32'd0);

        // Gap instance: 0x11..0x44, start 7 cycles after each done, 2-bit count wraps
        step(); empty_b = 1'b0; data_b = 8'h11; #1;
        step(); #1;
        check("b_first_load", 32'(load_b), 32'd1);
        step(); data_b = 8'h22; #1;
        check("b_first_start", 32'(start_b), 32'd1);
        check("b_first_data", 32'(tdata_b), 32'h11);
        frame_b(8'h22, 8'h33, 1'b0, 2'd1);
        frame_b(8'h33, 8'h44, 1'b0, 2'd2);
        frame_b(8'h44, 8'h00, 1'b1, 2'd3);
        step(); busy_b = 1'b1;
        step();
        step(); done_b = 1'b1;
        step(); done_b = 1'b0; busy_b = 1'b0; #1;
        check("b_wrap", 32'(cnt_b), 32'd0);
        check("b_gap_temt", 32'(temt_b), 32'd0);
        repeat (4) step();
        #1;
        check("b_idle_temt", 32'(temt_b), 32'd1);
        check("b_idle_load", 32'(load_b), 32'd0);

        // CTS flow control
        step(); afe = 1'b1; cts_n = 1'b1; empty_a = 1'b0; data_a = 8'h3C; #1;
        check("cts_block", 32'(load_a), 32'd0);
        repeat (3) begin
            step(); #1;
            check("cts_hold", 32'(load_a), 32'd0);
        end
        step(); cts_n = 1'b0; #1;
        check("cts_go_cycle", 32'(load_a), 32'd0);
        step(); #1;
        check("cts_pop", 32'(load_a), 32'd1);
        step(); data_a = 8'h4D; #1;
        check("cts_start", 32'(start_a), 32'd1);
        check("cts_data", 32'(tdata_a), 32'h3C);
        step(); busy_a = 1'b1; cts_n = 1'b1; #1;
        check("cts_send_temt", 32'(temt_a), 32'd0);
        step();
        step(); done_a = 1'b1;
        step(); done_a = 1'b0; busy_a = 1'b0; #1;
        check("cts_cnt", 32'(cnt_a), 32'd2);
        repeat (4) begin
            step(); #1;
            check("cts_no_pop", 32'(load_a), 32'd0);
        end

        // Break raised during START
        step(); afe = 1'b0; #1;
        check("brk_go_cycle", 32'(load_a), 32'd0);
        step(); #1;
        check("brk_pop", 32'(load_a), 32'd1);
        step(); brk = 1'b1; data_a = 8'h5E; #1;
        check("brk_start", 32'(start_a), 32'd1);
        check("brk_data", 32'(tdata_a), 32'h4D);
        step(); busy_a = 1'b1;
        step();
        step(); done_a = 1'b1;
        step(); done_a = 1'b0; busy_a = 1'b0; #1;
        check("brk_cnt", 32'(cnt_a), 32'd3);
        repeat (3) begin
            step(); #1;
            check("brk_hold", 32'(load_a), 32'd0);
        end
        step(); done_a = 1'b1;
        step(); done_a = 1'b0; #1;
        check("stray_done_cnt", 32'(cnt_a), 32'd3);
        check("stray_done_load", 32'(load_a), 32'd0);
        step(); brk = 1'b0; #1;
        check("brk_rel_cycle", 32'(load_a), 32'd0);
        step(); #1;
        check("brk_rel_pop", 32'(load_a), 32'd1);
        step(); empty_a = 1'b1; #1;
        check("last_start", 32'(start_a), 32'd1);
        check("last_data", 32'(tdata_a), 32'h5E);

        // Reset mid-frame, between clock edges
        step(); busy_a = 1'b1; #1;
        check("pre_rst_pulse", 32'(pulse_a), 32'd1);
        check("pre_rst_temt", 32'(temt_a), 32'd0);
        #2; preset = 1'b1; busy_a = 1'b0; #1;
        check("mid_rst_load", 32'(load_a), 32'd0);
        check("mid_rst_start", 32'(start_a), 32'd0);
        check("mid_rst_data", 32'(tdata_a), 32'h00);
        check("mid_rst_count", 32'(cnt_a), 32'd0);
        check("mid_rst_pulse", 32'(pulse_a), 32'd0);
        check("mid_rst_temt", 32'(temt_a), 32'd1);
        check("mid_rst_thre", 32'(thre_a), 32'd1);
        step(); preset = 1'b0;
        step(); #1;
        check("post_rst_pulse", 32'(pulse_a), 32'd0);
        check("post_rst_load", 32'(load_a), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Transmit-side sequencer for the UART: it decides when a character leaves the TX holding/FIFO buffer and enters the transmit shift register (TSR). It drives the buffer's read-enable (`tsr_load`) and hands each byte to the TSR with a start strobe. It enforces enable, break and CTS auto-flow-control gating, and inserts an optional inter-frame gap. It also produces the THRE/TEMT status and the THR-empty interrupt pulse consumed by the register/interrupt logic.

## Interface
- `GAP_CYCLES`, default 0: idle pclk cycles inserted after each frame before the next pop; range 0–255.
- `CNT_W`, default 16: width of the transmitted-byte counter.

Ports:
- `pclk`  in  1  APB/UART clock; all logic is on the rising edge.
- `preset`  in  1  asynchronous, active-high reset.
- `utrst`  in  1  transmitter enable; 0 means no new pops.
- `brk`  in  1  break control; 1 means no new pops.
- `afe`  in  1  auto-flow enable.
- `cts_n`  in  1  clear-to-send, active-low, already synchronised.
- `tx_fifo_empty`  in  1  buffer empty (THR or FIFO, per `fifoen`).
- `tx_data`  in  8  buffer head; valid in the same cycle as `tsr_load` (fall-through).
- `tsr_busy`  in  1  TSR shifting a frame.
- `tsr_done`  in  1  one-cycle pulse when the TSR finishes the stop bit.
- `tsr_load`  out  1  one-cycle pop strobe to the buffer.
- `tsr_start`  out  1  one-cycle start strobe to the TSR.
- `tsr_data`  out  8  registered byte for the TSR.
- `thre`  out  1  transmit holding register empty.
- `temt`  out  1  transmitter completely empty.
- `thre_pulse`  out  1  one-cycle interrupt request on `thre` rising.
- `tx_count`  out  `CNT_W`  frames completed; wraps.

## Operation
- FSM states and transitions:
  - IDLE → POP when `go = utrst & ~brk & ~tx_fifo_empty & ~tsr_busy & ~(afe & cts_n)`.
  - POP: assert `tsr_load`; latch `tx_data` into `tsr_data`; unconditionally → START.
  - START: assert `tsr_start`; → SEND.
  - SEND: wait for `tsr_done`; → GAP if `GAP_CYCLES > 0`, else → IDLE.
  - GAP: count down from `GAP_CYCLES - 1`; → IDLE at 0.
- Gating inputs (`utrst`, `brk`, `cts_n`) are sampled only in IDLE. Deasserting any of them in POP/START/SEND/GAP does not abort; the current frame completes and the FSM holds in IDLE afterwards.
- `tsr_done` is honoured only in SEND. A pulse in any other state is ignored and does not increment `tx_count`.
- `tx_count` increments by 1 on each `tsr_done` in SEND and wraps from all-ones to 0.
- Status outputs:
  - `thre = tx_fifo_empty` (combinational).
  - `temt = tx_fifo_empty & (state == IDLE) & ~tsr_busy`.
  - `thre_pulse` is registered: `thre & ~thre_q`, with `thre_q` reset to 1 so that no pulse fires out of reset.
- `tsr_data` holds its value until the next POP.

## Timing
- Reset values: state IDLE, `tsr_load` 0, `tsr_start` 0, `tsr_data` 0x00, `thre_pulse` 0, `tx_count` 0, gap counter 0. `thre`/`temt` follow their inputs (1 with an empty buffer and idle TSR).
- Latency: `go` true in cycle N → `tsr_load` in N+1 → `tsr_start` in N+2, with `tsr_data` valid from N+2.
- Back-to-back (GAP_CYCLES=0): `tsr_done` in cycle M → IDLE in M+1 → `tsr_load` in M+2 → `tsr_start` in M+3.
- With gap: the next `tsr_load` comes no earlier than M+2+GAP_CYCLES.
- Exactly one `tsr_load` and one `tsr_start` per frame. Neither is ever asserted in the same cycle as the other.
- The buffer going empty while in POP cannot occur (pop is committed). `tx_fifo_empty` changing after POP has no effect on the current frame.
- `preset` mid-frame returns to IDLE immediately and drops strobes asynchronously. The TSR is reset by the same signal.

## Structure
- `uart_pkg` holds `typedef enum logic [2:0] {TXC_IDLE, TXC_POP, TXC_START, TXC_SEND, TXC_GAP} tx_ctrl_state_e`. The TSR handshake widths are also package constants.
- Single module with no sub-modules. The gap counter and THRE edge detector are inline.

## Test plan
- Reset, empty buffer, `utrst=1` → `thre=1`, `temt=1`, `thre_pulse` stays 0, no `tsr_load`.
- Push 0xA5 with GAP_CYCLES=0 → `tsr_load` at N+1, `tsr_start` at N+2 with `tsr_data=0xA5`. After `tsr_done`: `tx_count=1`, `thre_pulse` fires once when the buffer empties.
- 3 bytes 0x11/0x22/0x33 with GAP_CYCLES=4 → start strobes in order, each following `tsr_done` by exactly 7 cycles, `tx_count=3`.
- `afe=1`, `cts_n=1` with data queued → no pop. Drop `cts_n` → pop in the next cycle. Raise `cts_n` in SEND → the frame completes and there is no further pop.
- `brk=1` asserted in START → `tsr_done` still completes the frame and counts, then the FSM holds in IDLE until `brk=0`. A stray `tsr_done` in IDLE leaves `tx_count` unchanged.
- Preload `tx_count` to 0xFFFF via 65535 frames (or force) → next frame wraps it to 0. Assert `preset` during SEND → all outputs at reset values in the same cycle.
